// File: rtl/dataformat.sv
// Packet field layout, type codes and the partial-sum node's FSM states,
// shared by the NoC nodes.
package dataformat;

    localparam int unsigned TYPE_MSB = 19;
    localparam int unsigned TYPE_LSB = 18;
    localparam int unsigned ADDR_MSB = 17;
    localparam int unsigned ADDR_LSB = 13;
    localparam int unsigned DEST_MSB = 12;
    localparam int unsigned DEST_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    localparam logic [1:0] PKT_IFMAP = 2'b01;
    localparam logic [1:0] PKT_PSUM  = 2'b10;
    localparam logic [1:0] PKT_OFMAP = 2'b11;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        DONE
    } psum_state_t;

endpackage

// File: rtl/psum_accumulator_if.sv
// Router-side packet streams of the partial-sum accumulator, plus its status pulses.
interface psum_accumulator_if #(
    parameter int unsigned DATA_WIDTH = 20
) ();
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  frame_done;
    logic                  pkt_err;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  frame_done,
        input  pkt_err
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output frame_done,
        output pkt_err
    );
endinterface

// File: rtl/psum_out_fifo.sv
// Synchronous result FIFO; a push is taken when not full, or when full with a
// simultaneous pop.
module psum_out_fifo #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty
);
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  wr_en;
    logic                  rd_en;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_WIDTH'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (rd_en) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (wr_en && !rd_en) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end else if (rd_en && !wr_en) begin
                count_q <= count_q - CNT_WIDTH'(1);
            end
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum reduction node: adds FILTER_WIDTH psums per ofmap address and
// emits one result packet per address, then pulses frame_done once drained.
module psum_accumulator
    import dataformat::*;
#(
    parameter int unsigned           DATA_WIDTH       = 20,
    parameter int unsigned           VALID_DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH       = 5,
    parameter int unsigned           FILTER_WIDTH     = 3,
    parameter int unsigned           OFMAP_SIZE       = 9,
    parameter logic [ADDR_WIDTH-1:0] SUM_INDEX        = '0,
    parameter logic [ADDR_WIDTH-1:0] MEM_INDEX        = '0,
    parameter int unsigned           FIFO_DEPTH       = 4
) (
    input logic               clk,
    input logic               rst_n,
    psum_accumulator_if.slave bus
);
    localparam int unsigned CNT_WIDTH  = $clog2(FILTER_WIDTH + 1);
    localparam int unsigned FCNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    psum_state_t state_q, state_d;

    logic [VALID_DATA_WIDTH-1:0] sum_q [OFMAP_SIZE];
    logic [VALID_DATA_WIDTH-1:0] sum_d [OFMAP_SIZE];
    logic [CNT_WIDTH-1:0]        cnt_q [OFMAP_SIZE];
    logic [CNT_WIDTH-1:0]        cnt_d [OFMAP_SIZE];
    logic [OFMAP_SIZE-1:0]       done_q, done_d;

    logic [1:0]                  pkt_type;
    logic [ADDR_WIDTH-1:0]       pkt_addr;
    logic [ADDR_WIDTH-1:0]       pkt_dest;
    logic [VALID_DATA_WIDTH-1:0] pkt_data;

    logic [VALID_DATA_WIDTH-1:0] cur_sum, new_sum;
    logic [CNT_WIDTH-1:0]        cur_cnt, new_cnt;
    logic                        cur_done, addr_hit;
    logic                        in_ready, ready_en_q;
    logic                        accept, pkt_ok, upd, completes;
    logic                        pkt_err_q;

    logic                        push, pop;
    logic [DATA_WIDTH-1:0]       push_data, fifo_data;
    logic [FCNT_WIDTH-1:0]       fifo_count;
    logic                        fifo_full, fifo_empty;

    assign pkt_type = bus.in_data[TYPE_MSB:TYPE_LSB];
    assign pkt_addr = bus.in_data[ADDR_MSB:ADDR_LSB];
    assign pkt_dest = bus.in_data[DEST_MSB:DEST_LSB];
    assign pkt_data = bus.in_data[DATA_MSB:DATA_LSB];

    // Address decode doubles as the addr < OFMAP_SIZE range check.
    always_comb begin
        cur_sum  = '0;
        cur_cnt  = '0;
        cur_done = 1'b0;
        addr_hit = 1'b0;
        for (int i = 0; i < OFMAP_SIZE; i++) begin
            if (pkt_addr == ADDR_WIDTH'(i)) begin
                addr_hit = 1'b1;
                cur_sum  = sum_q[i];
                cur_cnt  = cnt_q[i];
                cur_done = done_q[i];
            end
        end
    end

    assign in_ready  = ready_en_q && (state_q == ACCUM) && !fifo_full;
    assign accept    = bus.in_valid && in_ready;
    assign pkt_ok    = (pkt_type == PKT_PSUM) && addr_hit && (pkt_dest == SUM_INDEX) && !cur_done;
    assign upd       = accept && pkt_ok;
    assign new_sum   = cur_sum + pkt_data;
    assign new_cnt   = cur_cnt + CNT_WIDTH'(1);
    assign completes = (new_cnt == CNT_WIDTH'(FILTER_WIDTH));
    assign push      = upd && completes;
    assign push_data = {PKT_OFMAP, pkt_addr, MEM_INDEX, new_sum};
    assign pop       = bus.out_ready && !fifo_empty;

    always_comb begin
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        for (int i = 0; i < OFMAP_SIZE; i++) begin
            if (upd && (pkt_addr == ADDR_WIDTH'(i))) begin
                if (completes) begin
                    sum_d[i]  = '0;
                    cnt_d[i]  = '0;
                    done_d[i] = 1'b1;
                end else begin
                    sum_d[i] = new_sum;
                    cnt_d[i] = new_cnt;
                end
            end
        end
        if (state_q == DONE) begin
            done_d = '0;
        end
    end

    // Leave DRAIN as soon as the last result leaves, so frame_done follows the final pop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (push && (&done_d)) state_d = DRAIN;
            DRAIN: if (fifo_empty || (pop && fifo_count == FCNT_WIDTH'(1))) state_d = DONE;
            DONE:  state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            ready_en_q <= 1'b0;
            pkt_err_q  <= 1'b0;
            done_q     <= '0;
            for (int i = 0; i < OFMAP_SIZE; i++) begin
                sum_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            pkt_err_q  <= accept && !pkt_ok;
            done_q     <= done_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
        end
    end

    psum_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = fifo_data;
    assign bus.frame_done = (state_q == DONE);
    assign bus.pkt_err    = pkt_err_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized bench for psum_accumulator against a per-address list-sum model.
module tb_psum_accumulator;
    import dataformat::*;

    localparam logic [4:0] SUM_IDX = 5'd3;
    localparam logic [4:0] MEM_IDX = 5'd7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    psum_accumulator_if #(.DATA_WIDTH(20)) bus ();

    psum_accumulator #(
        .DATA_WIDTH       (20),
        .VALID_DATA_WIDTH (8),
        .ADDR_WIDTH       (5),
        .FILTER_WIDTH     (3),
        .OFMAP_SIZE       (9),
        .SUM_INDEX        (SUM_IDX),
        .MEM_INDEX        (MEM_IDX),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0, last_pop_cyc = -1, done_cyc = -1, err_pulses = 0, done_pulses = 0;
    bit rand_ready = 1'b0;

    // Model: total of accepted data and count per address; result = total mod 256.
    int m_total[9];
    int m_n[9];
    bit m_done[9];
    int m_frames = 0, m_errs = 0;
    logic [19:0] exp_q[$];
    logic [19:0] got_q[$];

    function automatic logic [19:0] mk(input logic [1:0] t, input int a, input logic [4:0] d,
                                       input int v);
        return {t, 5'(a), d, 8'(v)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) begin
            m_total[i] = 0;
            m_n[i] = 0;
            m_done[i] = 1'b0;
        end
        m_frames = 0;
        m_errs = 0;
        exp_q.delete();
        got_q.delete();
        err_pulses = 0;
        done_pulses = 0;
        last_pop_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic model_accept(input logic [19:0] p);
        int a;
        bit all;
        a = int'(p[17:13]);
        if (p[19:18] != 2'b10 || a >= 9 || p[12:8] != SUM_IDX) begin
            m_errs++;
        end else if (m_done[a]) begin
            m_errs++;
        end else begin
            m_total[a] += int'(p[7:0]);
            m_n[a]++;
            if (m_n[a] == 3) begin
                exp_q.push_back({2'b11, p[17:13], MEM_IDX, 8'(m_total[a] % 256)});
                m_total[a] = 0;
                m_n[a] = 0;
                m_done[a] = 1'b1;
                all = 1'b1;
                for (int i = 0; i < 9; i++) if (!m_done[i]) all = 1'b0;
                if (all) begin
                    m_frames++;
                    for (int i = 0; i < 9; i++) m_done[i] = 1'b0;
                end
            end
        end
    endtask

    // Called at a falling edge: log what the next rising edge transfers, then advance.
    task automatic cycle(output bit acc);
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            last_pop_cyc = cyc;
        end
        if (acc) model_accept(bus.in_data);
        @(negedge clk);
        cyc++;
        if (bus.pkt_err) err_pulses++;
        if (bus.frame_done) begin
            done_pulses++;
            done_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic send(input logic [19:0] p);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        bus.in_data = p;
        bus.in_valid = 1'b1;
        while (!acc && n < 200) begin
            cycle(acc);
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: accepted=0 required=1 pkt=%h", p);
        end
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        rand_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_clear();
        rst_n = 1'b1;
        @(negedge clk);
        cyc++;
    endtask

    task automatic shuffle(inout logic [19:0] pk[$]);
        logic [19:0] tmp;
        int j;
        for (int i = pk.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = pk[i];
            pk[i] = pk[j];
            pk[j] = tmp;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_data !== 20'h0) begin miscompares++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
        vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_frame_done: got %b want 0", bus.frame_done); end
        vectors++; if (bus.pkt_err !== 1'b0) begin miscompares++; $display("FAIL rst_pkt_err: got %b want 0", bus.pkt_err); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rel_in_ready: got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rel_out_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_sequential();
        logic [19:0] want;
        want = {2'b11, 5'd4, MEM_IDX, 8'd15};
        apply_reset();
        bus.out_ready = 1'b1;
        send(mk(PKT_PSUM, 4, SUM_IDX, 3));
        send(mk(PKT_PSUM, 4, SUM_IDX, 5));
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL seq_early_valid: got %b want 0", bus.out_valid); end
        send(mk(PKT_PSUM, 4, SUM_IDX, 7));
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL seq_latency_valid: got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_data !== want) begin miscompares++; $display("FAIL seq_latency_data: got %h want %h", bus.out_data, want); end
        idle(4);
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL seq_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            vectors++; if (got_q[0] !== want) begin miscompares++; $display("FAIL seq_result: got %h want %h", got_q[0], want); end
        end
    endtask

    task automatic test_full_frame();
        logic [19:0] pk[$];
        int n;
        apply_reset();
        bus.out_ready = 1'b1;
        for (int a = 0; a < 9; a++) for (int k = 0; k < 3; k++) pk.push_back(mk(PKT_PSUM, a, SUM_IDX, a + 1));
        shuffle(pk);
        foreach (pk[i]) begin
            send(pk[i]);
            idle(int'($urandom_range(0, 1)));
        end
        n = 0;
        while (done_pulses == 0 && n < 60) begin idle(1); n++; end
        idle(4);
        vectors++; if (got_q.size() != 9) begin miscompares++; $display("FAIL frame_count: got %0d want 9", got_q.size()); end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL frame_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        vectors++; if (done_pulses != 1) begin miscompares++; $display("FAIL frame_done_pulses: got %0d want 1", done_pulses); end
        vectors++; if (done_cyc != last_pop_cyc + 1) begin miscompares++; $display("FAIL frame_done_timing: got cycle %0d want %0d", done_cyc, last_pop_cyc + 1); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL frame_rearm: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_wrap_backpressure();
        logic [19:0] first;
        bit acc;
        first = {2'b11, 5'd0, MEM_IDX, 8'd54};
        apply_reset();
        send(mk(PKT_PSUM, 0, SUM_IDX, 200));
        send(mk(PKT_PSUM, 0, SUM_IDX, 100));
        send(mk(PKT_PSUM, 0, SUM_IDX, 10));
        for (int a = 1; a < 4; a++) for (int k = 0; k < 3; k++) send(mk(PKT_PSUM, a, SUM_IDX, int'($urandom_range(0, 255))));
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
        bus.in_data = mk(PKT_PSUM, 5, SUM_IDX, 1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(acc);
            vectors++; if (bus.out_data !== first || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", i, bus.out_valid, bus.out_data, first); end
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cycle(acc);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_return: got %b want 1", bus.in_ready); end
        idle(6);
        vectors++; if (got_q.size() != 4) begin miscompares++; $display("FAIL bp_count: got %0d want 4", got_q.size()); end
        if (got_q.size() >= 1) begin
            vectors++; if (got_q[0] !== first) begin miscompares++; $display("FAIL bp_wrap: got %h want %h", got_q[0], first); end
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_errors();
        apply_reset();
        bus.out_ready = 1'b1;
        send(mk(PKT_IFMAP, 1, SUM_IDX, 50));
        vectors++; if (bus.pkt_err !== 1'b1) begin miscompares++; $display("FAIL err_type: got %b want 1", bus.pkt_err); end
        send(mk(PKT_PSUM, 9, SUM_IDX, 1));
        vectors++; if (bus.pkt_err !== 1'b1) begin miscompares++; $display("FAIL err_addr: got %b want 1", bus.pkt_err); end
        send(mk(PKT_PSUM, 2, SUM_IDX + 5'd1, 1));
        vectors++; if (bus.pkt_err !== 1'b1) begin miscompares++; $display("FAIL err_dest: got %b want 1", bus.pkt_err); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL err_no_output: got %b want 0", bus.out_valid); end
        send(mk(PKT_PSUM, 1, SUM_IDX, 1));
        send(mk(PKT_PSUM, 1, SUM_IDX, 2));
        send(mk(PKT_PSUM, 1, SUM_IDX, 3));
        vectors++; if (bus.pkt_err !== 1'b0) begin miscompares++; $display("FAIL err_valid_pkt: got %b want 0", bus.pkt_err); end
        idle(2);
        send(mk(PKT_PSUM, 1, SUM_IDX, 4));
        vectors++; if (bus.pkt_err !== 1'b1) begin miscompares++; $display("FAIL err_late: got %b want 1", bus.pkt_err); end
        idle(4);
        vectors++; if (err_pulses != m_errs) begin miscompares++; $display("FAIL err_pulses: got %0d want %0d", err_pulses, m_errs); end
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL err_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL err_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] pk[$];
        int n;
        apply_reset();
        for (int a = 0; a < 4; a++) for (int k = 0; k < 3; k++) send(mk(PKT_PSUM, a, SUM_IDX, int'($urandom_range(0, 255))));
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full_ready: got %b want 0", bus.in_ready); end
        for (int a = 4; a < 9; a++) for (int k = 0; k < 3; k++) pk.push_back(mk(PKT_PSUM, a, SUM_IDX, int'($urandom_range(0, 255))));
        shuffle(pk);
        rand_ready = 1'b1;
        foreach (pk[i]) send(pk[i]);
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (done_pulses == 0 && n < 80) begin idle(1); n++; end
        idle(3);
        vectors++; if (got_q.size() != 9) begin miscompares++; $display("FAIL b2b_count: got %0d want 9", got_q.size()); end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        vectors++; if (done_pulses != m_frames) begin miscompares++; $display("FAIL b2b_frame_done: got %0d want %0d", done_pulses, m_frames); end
    endtask

    task automatic test_midframe_reset();
        logic [19:0] want;
        want = {2'b11, 5'd5, MEM_IDX, 8'd60};
        apply_reset();
        send(mk(PKT_PSUM, 5, SUM_IDX, 9));
        send(mk(PKT_PSUM, 5, SUM_IDX, 9));
        for (int k = 0; k < 3; k++) send(mk(PKT_PSUM, 6, SUM_IDX, 1));
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_buffered: got %b want 1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_data !== 20'h0) begin miscompares++; $display("FAIL mid_out_data: got %h want 0", bus.out_data); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_in_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        apply_reset();
        bus.out_ready = 1'b1;
        send(mk(PKT_PSUM, 5, SUM_IDX, 10));
        send(mk(PKT_PSUM, 5, SUM_IDX, 20));
        send(mk(PKT_PSUM, 5, SUM_IDX, 30));
        idle(3);
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL mid_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            vectors++; if (got_q[0] !== want) begin miscompares++; $display("FAIL mid_fresh_sum: got %h want %h", got_q[0], want); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full_frame();
        test_wrap_backpressure();
        test_errors();
        test_back_to_back();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
